// File: rtl/morse_keyer_if.sv
// Letter request / display-and-key bus for the Morse keyer.
// The master side supplies start/letter and observes the keyer outputs;
// the slave side is the keyer itself.
interface morse_keyer_if;
  logic       start;
  logic [4:0] letter;
  logic [4:0] shift;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, letter,
    input  shift, key_out, busy, done, err
  );

  modport slave (
    input  start, letter,
    output shift, key_out, busy, done, err
  );
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: plays the Morse pattern of a 5-bit letter code (1..26 = A..Z)
// as a timed key signal, and presents the letter code on the display bus.
// Build option MORSE_SHIFT_HOLD_EN: when defined, shift keeps the last sent
// letter after done instead of blanking to 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; invalid codes pulse err
// MARK  | key on for one element (1 unit dot, 3 units dash)
// GAP   | key off for 1 unit between elements of the same letter
// LGAP  | key off for 3 units closing the letter, then done pulse
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 12500000
) (
  input  logic           clk,
  input  logic           rst,
  morse_keyer_if.slave   bus
);

  localparam int UW = (UNIT_CYCLES < 2) ? 1 : $clog2(UNIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

  state_t        state;
  logic [4:0]    shift_r;
  logic          key_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic [3:0]    pat_r;
  logic [2:0]    rem_r;
  logic [UW-1:0] ucnt;
  logic [1:0]    ecnt;

  logic [2:0]    rom_len;
  logic [3:0]    rom_pat;
  logic          valid;
  logic          tick;
  logic [1:0]    tgt_m1;
  logic          last_unit;

  // Morse alphabet ROM: element count and MSB-first pattern (1 = dash)
  always_comb begin
    rom_len = 3'd0;
    rom_pat = 4'b0000;
    case (bus.letter)
      5'd1:  begin rom_len = 3'd2; rom_pat = 4'b0100; end // A .-
      5'd2:  begin rom_len = 3'd4; rom_pat = 4'b1000; end // B -...
      5'd3:  begin rom_len = 3'd4; rom_pat = 4'b1010; end // C -.-.
      5'd4:  begin rom_len = 3'd3; rom_pat = 4'b1000; end // D -..
      5'd5:  begin rom_len = 3'd1; rom_pat = 4'b0000; end // E .
      5'd6:  begin rom_len = 3'd4; rom_pat = 4'b0010; end // F ..-.
      5'd7:  begin rom_len = 3'd3; rom_pat = 4'b1100; end // G --.
      5'd8:  begin rom_len = 3'd4; rom_pat = 4'b0000; end // H ....
      5'd9:  begin rom_len = 3'd2; rom_pat = 4'b0000; end // I ..
      5'd10: begin rom_len = 3'd4; rom_pat = 4'b0111; end // J .---
      5'd11: begin rom_len = 3'd3; rom_pat = 4'b1010; end // K -.-
      5'd12: begin rom_len = 3'd4; rom_pat = 4'b0100; end // L .-..
      5'd13: begin rom_len = 3'd2; rom_pat = 4'b1100; end // M --
      5'd14: begin rom_len = 3'd2; rom_pat = 4'b1000; end // N -.
      5'd15: begin rom_len = 3'd3; rom_pat = 4'b1110; end // O ---
      5'd16: begin rom_len = 3'd4; rom_pat = 4'b0110; end // P .--.
      5'd17: begin rom_len = 3'd4; rom_pat = 4'b1101; end // Q --.-
      5'd18: begin rom_len = 3'd3; rom_pat = 4'b0100; end // R .-.
      5'd19: begin rom_len = 3'd3; rom_pat = 4'b0000; end // S ...
      5'd20: begin rom_len = 3'd1; rom_pat = 4'b1000; end // T -
      5'd21: begin rom_len = 3'd3; rom_pat = 4'b0010; end // U ..-
      5'd22: begin rom_len = 3'd4; rom_pat = 4'b0001; end // V ...-
      5'd23: begin rom_len = 3'd3; rom_pat = 4'b0110; end // W .--
      5'd24: begin rom_len = 3'd4; rom_pat = 4'b1001; end // X -..-
      5'd25: begin rom_len = 3'd4; rom_pat = 4'b1011; end // Y -.--
      5'd26: begin rom_len = 3'd4; rom_pat = 4'b1100; end // Z --..
      default: begin rom_len = 3'd0; rom_pat = 4'b0000; end
    endcase
  end

  assign valid = (rom_len != 3'd0);
  assign tick  = (ucnt == UW'(UNIT_CYCLES - 1));

  // Units-per-state minus one: element count at which the last unit ends
  always_comb begin
    tgt_m1 = 2'd0;
    case (state)
      MARK:    tgt_m1 = pat_r[3] ? 2'd2 : 2'd0;
      GAP:     tgt_m1 = 2'd0;
      LGAP:    tgt_m1 = 2'd2;
      default: tgt_m1 = 2'd0;
    endcase
  end

  assign last_unit = tick && (ecnt == tgt_m1);

  // Sequencer: timing counters, element walk and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_r <= 5'd0;
      key_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      pat_r   <= 4'b0000;
      rem_r   <= 3'd0;
      ucnt    <= '0;
      ecnt    <= 2'd0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;

      // unit timer runs in every active state; exits below restart it
      if (state != IDLE) begin
        if (tick) begin
          ucnt <= '0;
          ecnt <= ecnt + 2'd1;
        end else begin
          ucnt <= ucnt + UW'(1);
        end
      end

      case (state)
        IDLE: begin
          ucnt <= '0;
          ecnt <= 2'd0;
          if (bus.start) begin
            if (valid) begin
              shift_r <= bus.letter;
              pat_r   <= rom_pat;
              rem_r   <= rom_len;
              busy_r  <= 1'b1;
              key_r   <= 1'b1;
              state   <= MARK;
            end else begin
              err_r <= 1'b1;
            end
          end
        end

        MARK: begin
          if (last_unit) begin
            key_r <= 1'b0;
            ucnt  <= '0;
            ecnt  <= 2'd0;
            if (rem_r > 3'd1) begin
              rem_r <= rem_r - 3'd1;
              pat_r <= {pat_r[2:0], 1'b0};
              state <= GAP;
            end else begin
              state <= LGAP;
            end
          end
        end

        GAP: begin
          if (last_unit) begin
            key_r <= 1'b1;
            ucnt  <= '0;
            ecnt  <= 2'd0;
            state <= MARK;
          end
        end

        LGAP: begin
          if (last_unit) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            ucnt   <= '0;
            ecnt   <= 2'd0;
`ifdef MORSE_SHIFT_HOLD_EN
            shift_r <= shift_r;
`else
            shift_r <= 5'd0;
`endif
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.shift   = shift_r;
  assign bus.key_out = key_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_morse_keyer.sv
// Testbench for morse_keyer: directed and randomized letters checked cycle by
// cycle against a waveform built from the Morse alphabet as dot/dash strings.
module tb_morse_keyer;

  logic clk;
  logic rst;

  morse_keyer_if a();
  morse_keyer_if b();

  morse_keyer #(.UNIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(a.slave));
  morse_keyer #(.UNIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit wave[$];
  logic [4:0] last_shift;

  string morse [0:26] = '{"", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                          "....", "..", ".---", "-.-", ".-..", "--", "-.",
                          "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                          "...-", ".--", "-..-", "-.--", "--.."};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // key waveform for one letter: marks, 1-unit gaps, closing 3-unit gap
  function automatic void build_wave(input string m, input int u);
    wave.delete();
    for (int i = 0; i < m.len(); i++) begin
      int n;
      n = (m[i] == "-") ? 3 * u : u;
      for (int j = 0; j < n; j++) wave.push_back(1'b1);
      if (i != m.len() - 1)
        for (int j = 0; j < u; j++) wave.push_back(1'b0);
    end
    for (int j = 0; j < 3 * u; j++) wave.push_back(1'b0);
  endfunction

  function automatic logic [4:0] after_done(input logic [4:0] l);
`ifdef MORSE_SHIFT_HOLD_EN
    return l;
`else
    return 5'd0;
`endif
  endfunction

  // Send one letter on the UNIT_CYCLES=4 instance and check every cycle
  task automatic send(input logic [4:0] l, input bit noise);
    int total;
    build_wave(morse[l], 4);
    total = wave.size();
    @(negedge clk);
    a.start = 1'b1;
    a.letter = l;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      check("key_out", a.key_out, (k <= total) ? wave[k-1] : 1'b0);
      check("busy",    a.busy,    (k <= total) ? 1 : 0);
      check("done",    a.done,    (k == total + 1) ? 1 : 0);
      check("err",     a.err,     0);
      check("shift",   a.shift,   (k <= total) ? l : after_done(l));
      if (k < total && noise) begin
        a.start  = 1'($urandom_range(0, 1));
        a.letter = 5'($urandom_range(0, 31));
      end else begin
        a.start = 1'b0;
      end
    end
    last_shift = after_done(l);
  endtask

  task automatic try_invalid(input logic [4:0] l);
    @(negedge clk);
    a.start = 1'b1;
    a.letter = l;
    @(negedge clk);
    check("err_pulse", a.err, 1);
    check("err_busy",  a.busy, 0);
    check("err_shift", a.shift, last_shift);
    a.start = 1'b0;
    @(negedge clk);
    check("err_clear", a.err, 0);
    check("err_shift2", a.shift, last_shift);
  endtask

  initial begin
    logic [4:0] rl;
    rst = 1'b1;
    a.start = 1'b0; a.letter = 5'd0;
    b.start = 1'b0; b.letter = 5'd0;
    last_shift = 5'd0;
    #1;
    check("rst_shift", a.shift, 0);
    check("rst_key",   a.key_out, 0);
    check("rst_busy",  a.busy, 0);
    check("rst_done",  a.done, 0);
    check("rst_err",   a.err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset in the middle of A
    @(negedge clk);
    a.start = 1'b1; a.letter = 5'd1;
    @(negedge clk);
    a.start = 1'b0;
    check("midA_busy", a.busy, 1);
    repeat (9) @(negedge clk);
    check("midA_key", a.key_out, 1);
    rst = 1'b1;
    #1;
    check("arst_shift", a.shift, 0);
    check("arst_key",   a.key_out, 0);
    check("arst_busy",  a.busy, 0);
    check("arst_done",  a.done, 0);
    check("arst_err",   a.err, 0);
    @(negedge clk);
    rst = 1'b0;
    last_shift = 5'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("abort_done", a.done, 0);
      check("abort_busy", a.busy, 0);
    end
    send(5'd20, 1'b0);

    // directed letters
    send(5'd5, 1'b0);
    send(5'd1, 1'b0);
    send(5'd17, 1'b0);
    send(5'd26, 1'b1);

    // invalid codes and start while busy
    try_invalid(5'd0);
    try_invalid(5'd27);
    try_invalid(5'($urandom_range(27, 31)));

    // random letters with random start/letter noise while busy
    for (int i = 0; i < 20; i++) begin
      rl = 5'($urandom_range(1, 26));
      send(rl, 1'b1);
      if ($urandom_range(0, 3) == 0) try_invalid(5'($urandom_range(27, 31)));
    end

    // held start with T on the UNIT_CYCLES=1 instance
    build_wave(morse[20], 1);
    @(negedge clk);
    b.start = 1'b1; b.letter = 5'd20;
    for (int k = 1; k <= 28; k++) begin
      int p;
      @(negedge clk);
      p = (k - 1) % 7;
      check("held_key",   b.key_out, (p < 6) ? wave[p] : 1'b0);
      check("held_busy",  b.busy, (p < 6) ? 1 : 0);
      check("held_done",  b.done, (p == 6) ? 1 : 0);
      check("held_shift", b.shift, (p < 6) ? 5'd20 : after_done(5'd20));
      if (k == 28) b.start = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rel_busy",  b.busy, 0);
      check("rel_shift", b.shift, after_done(5'd20));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Upstream sequencing stage of the Morse code generator.
- Accepts a 5-bit letter code and plays its Morse pattern as a timed on/off key signal.
- Presents the letter code being sent on a 5-bit shift bus that feeds the 7-segment display decoder directly.
- Timing is expressed in Morse units of UNIT_CYCLES clocks.

Parameters:
UNIT_CYCLES, 12500000, clock cycles per Morse unit (0.25 s at 50 MHz); legal range 1 to 2^24-1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  request to send letter; sampled only in IDLE.
letter  input  5  letter code: 1..26 = A..Z; 0 and 27..31 invalid.
shift  output  5  registered letter code under transmission; drives display decoder.
key_out  output  1  registered Morse key: 1 = mark (tone/LED on).
busy  output  1  high while a letter is being sent.
done  output  1  one-cycle pulse at end of letter.
err  output  1  one-cycle pulse when start arrives with an invalid code.

Behaviour:
- Reset: one clock, asynchronous active-high. Asserting rst forces, immediately and regardless of state:
  - state = IDLE;
  - shift = 0, key_out = 0, busy = 0, done = 0, err = 0;
  - unit counter and element counter cleared.
- Reset mid-transmission aborts the letter silently: no done pulse.
- Internal ROM, combinational, indexed by letter, gives:
  - len, 3 bits, 1..4: number of elements;
  - pat, 4 bits: elements MSB-first, 1 = dash, 0 = dot.
  - Content is the standard international Morse alphabet, e.g. A = .-, B = -..., E = ., T = -, Q = --.-, Z = --..
- States: IDLE, MARK, GAP, LGAP.
- IDLE, start=1, valid letter, at the accepting edge:
  - shift <= letter; pattern and element count loaded;
  - busy <= 1, key_out <= 1; state -> MARK.
  - key_out therefore rises on the same edge as busy (zero added latency).
- IDLE, start=1, invalid letter: err pulses for 1 cycle; state stays IDLE; shift unchanged.
- MARK:
  - key_out = 1 for 1 unit (dot) or 3 units (dash).
  - Then, if elements remain: -> GAP. Otherwise: -> LGAP.
  - key_out <= 0 on the exit edge.
- GAP: key_out = 0 for 1 unit, then -> MARK with the next element; key_out <= 1 on that edge.
- LGAP: key_out = 0 for 3 units. On the final edge:
  - busy <= 0, done <= 1 for one cycle;
  - shift <= 0 (see Optional Feature);
  - state -> IDLE.
- Total busy duration = sum(element units) + (len-1) intra-letter gaps + 3 units.
  - Example, A: 1+1+3+3 = 8 units.
- Unit counter:
  - Counts 0..UNIT_CYCLES-1 and wraps; a unit tick occurs on wrap.
  - Restarts at 0 on every state entry.
  - Width = $clog2(UNIT_CYCLES+1), minimum 1.
- Element counter counts units within the current state (max 3); no overflow is possible.
- start while busy=1 is ignored (no queueing, no err).
- start held high continuously: a new letter is accepted on the first IDLE cycle after done. Back-to-back letters are separated only by LGAP.
- letter changes while busy have no effect; the pattern and shift are latched at acceptance.
- UNIT_CYCLES = 1: each unit is one clock; behaviour otherwise identical.

Optional Feature:
- Macro: MORSE_SHIFT_HOLD_EN.
- Defined: shift keeps the last sent letter code after done, until the next valid acceptance or reset. The display keeps showing the last letter.
- Undefined (default): shift returns to 0 on the done edge, blanking the display between letters.

Test Plan (UNIT_CYCLES=4 override unless stated):
- Reset mid-letter: start letter=1 (A), assert rst 10 cycles later -> all outputs 0 immediately (asynchronous); no done pulse; a subsequent start of 20 (T) behaves normally.
- E: start letter=5 for 1 cycle -> key_out high 4 cycles; busy high 16 cycles; done pulses at cycle 16; shift=5 during busy, then 0.
- A: letter=1 -> key_out pattern 4 on, 4 off, 12 on, 12 off; busy 32 cycles; one done pulse.
- Q: letter=17 -> key_out 12 on, 4 off, 12 on, 4 off, 4 on, 4 off, 12 on, then 12 off; busy 64 cycles.
- Invalid and busy cases: start with letter=0 and with letter=27 -> one err pulse each, busy stays 0, shift unchanged. start pulsed during an active letter -> ignored, no err.
- Held start with letter=20 (T), UNIT_CYCLES=1 -> letters repeat every 7 cycles (6 busy + 1 IDLE). Build with MORSE_SHIFT_HOLD_EN -> shift stays 20 through the IDLE cycle and after start is released.
